mutex_arbiter: RTL and testbench

- Clocked two-way mutual-exclusion element.
- Two independent requesters (r1, r2) compete for one shared resource. At most one grant (g1, g2) is asserted at any time.
- A grant is held until its requester withdraws the request.
- Sits between asynchronous/handshake request sources and a shared resource. Requests are synchronized internally.

---
 rtl/mutex_pkg.sv | 14 +
 rtl/mutex_arbiter_req_sync.sv | 24 ++
 rtl/mutex_arbiter.sv | 61 ++++++
 tb/tb_mutex_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mutex_pkg.sv
// mutex_pkg: shared FSM state type and requester IDs for the two-way mutex arbiter.
package mutex_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT1 = 2'd1,
      GRANT2 = 2'd2
   } state_e;

   // Requester IDs as stored in the last_grant register.
   localparam logic REQ1 = 1'b0;
   localparam logic REQ2 = 1'b1;

endpackage

// File: rtl/mutex_arbiter_req_sync.sv
// req_sync: N-stage single-bit synchronizer with async reset to 0; N=0 is a plain wire.
module req_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   if (N == 0) begin : g_bypass
      assign q_o = d_i;
   end else begin : g_sync
      logic [N-1:0] sync_q;
      logic [N:0]   chain_d;
      assign chain_d = {sync_q, d_i};
      always_ff @(posedge clk or posedge rst) begin
         if (rst) sync_q <= '0;
         else     sync_q <= chain_d[N-1:0];
      end
      assign q_o = sync_q[N-1];
   end

endmodule

// File: rtl/mutex_arbiter.sv
// mutex_arbiter: clocked two-way mutual exclusion with synchronized requests,
// alternating tie-break and a mandatory idle guard cycle between grants.
module mutex_arbiter
   import mutex_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic r1,
   input  logic r2,
   output logic g1,
   output logic g2
);

   logic   r1s, r2s;
   state_e state_q, state_d;
   logic   last_q, last_d;
   logic   g1_q, g2_q;

   req_sync #(.N(SYNC_STAGES)) u_sync_r1 (.clk(clk), .rst(rst), .d_i(r1), .q_o(r1s));
   req_sync #(.N(SYNC_STAGES)) u_sync_r2 (.clk(clk), .rst(rst), .d_i(r2), .q_o(r2s));

   // A grant state can only fall back to IDLE, which enforces the guard cycle.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE:    state_d = (r1s && (!r2s || last_q == REQ2)) ? GRANT1 :
                            r2s ? GRANT2 : IDLE;
         GRANT1: begin
            state_d = r1s ? GRANT1 : IDLE;
            last_d  = r1s ? last_q : REQ1;
         end
         GRANT2: begin
            state_d = r2s ? GRANT2 : IDLE;
            last_d  = r2s ? last_q : REQ2;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so grants appear on the same edge as the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= REQ2;
         g1_q    <= 1'b0;
         g2_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         g1_q    <= (state_d == GRANT1);
         g2_q    <= (state_d == GRANT2);
      end
   end

   assign g1 = g1_q;
   assign g2 = g2_q;

endmodule

// File: tb/tb_mutex_arbiter.sv
// tb_mutex_arbiter: scoreboard bench; each scenario queues expected {g1,g2} per edge and checks them.
module tb_mutex_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic r1  = 1'b0;
   logic r2  = 1'b0;
   logic g1, g2;
   int   checks = 0;
   int   errors = 0;
   logic [1:0] exp_q[$];

   always #5 clk = ~clk;

   mutex_arbiter #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .r1(r1), .r2(r2), .g1(g1), .g2(g2)
   );

   always @(negedge clk) begin
      checks++;
      if (g1 && g2) begin
         errors++;
         $display("FAIL overlap g1=%b g2=%b at %0t (required not both 1)", g1, g2, $time);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [1:0] exp;
      rst = 1'b1; r1 = 1'b0; r2 = 1'b0;
      tick();
      checks++;
      if ({g1, g2} !== 2'b00) begin
         errors++;
         $display("FAIL reset_hold g1g2=%b required 00", {g1, g2});
      end
      rst = 1'b0;
      repeat (10) exp_q.push_back(2'b00);
      while (exp_q.size() > 0) begin
         tick();
         exp = exp_q.pop_front();
         checks++;
         if ({g1, g2} !== exp) begin
            errors++;
            $display("FAIL idle g1g2=%b required %b", {g1, g2}, exp);
         end
      end
   endtask

   task automatic test_tie();
      logic [1:0] exp;
      r1 = 1'b1; r2 = 1'b1;
      exp_q.push_back(2'b00); exp_q.push_back(2'b00); exp_q.push_back(2'b10);
      exp_q.push_back(2'b10); exp_q.push_back(2'b10);
      while (exp_q.size() > 0) begin
         tick();
         exp = exp_q.pop_front();
         checks++;
         if ({g1, g2} !== exp) begin
            errors++;
            $display("FAIL tie g1g2=%b required %b", {g1, g2}, exp);
         end
      end
   endtask

   task automatic test_drop_other();
      logic [1:0] exp;
      r2 = 1'b0;
      repeat (5) exp_q.push_back(2'b10);
      while (exp_q.size() > 0) begin
         tick();
         exp = exp_q.pop_front();
         checks++;
         if ({g1, g2} !== exp) begin
            errors++;
            $display("FAIL drop_other g1g2=%b required %b", {g1, g2}, exp);
         end
      end
   endtask

   task automatic test_handover();
      logic [1:0] exp;
      r1 = 1'b0; r2 = 1'b1;
      exp_q.push_back(2'b10); exp_q.push_back(2'b10); exp_q.push_back(2'b00);
      exp_q.push_back(2'b01); exp_q.push_back(2'b01);
      while (exp_q.size() > 0) begin
         tick();
         exp = exp_q.pop_front();
         checks++;
         if ({g1, g2} !== exp) begin
            errors++;
            $display("FAIL handover g1g2=%b required %b", {g1, g2}, exp);
         end
      end
   endtask

   // Starts with g2 held; each round releases the holder while the other waits.
   task automatic test_alternate();
      logic [1:0] exp;
      logic [1:0] hold, other;
      r1 = 1'b1; r2 = 1'b1;
      hold = 2'b01;
      for (int k = 0; k < 4; k++) begin
         other = ~hold;
         if (hold == 2'b10) r1 = 1'b0;
         else               r2 = 1'b0;
         exp_q.push_back(hold); exp_q.push_back(hold); exp_q.push_back(2'b00);
         exp_q.push_back(other); exp_q.push_back(other);
         while (exp_q.size() > 0) begin
            tick();
            exp = exp_q.pop_front();
            checks++;
            if ({g1, g2} !== exp) begin
               errors++;
               $display("FAIL alternate round %0d g1g2=%b required %b", k, {g1, g2}, exp);
            end
         end
         r1 = 1'b1; r2 = 1'b1;
         repeat (4) exp_q.push_back(other);
         while (exp_q.size() > 0) begin
            tick();
            exp = exp_q.pop_front();
            checks++;
            if ({g1, g2} !== exp) begin
               errors++;
               $display("FAIL no_preempt round %0d g1g2=%b required %b", k, {g1, g2}, exp);
            end
         end
         hold = other;
      end
   endtask

   task automatic test_reset_mid_grant();
      logic [1:0] exp;
      r1 = 1'b0;
      repeat (4) tick();
      checks++;
      if ({g1, g2} !== 2'b01) begin
         errors++;
         $display("FAIL pre_reset g1g2=%b required 01", {g1, g2});
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({g1, g2} !== 2'b00) begin
         errors++;
         $display("FAIL async_reset g1g2=%b required 00", {g1, g2});
      end
      tick(); tick();
      rst = 1'b0;
      exp_q.push_back(2'b00); exp_q.push_back(2'b00); exp_q.push_back(2'b01);
      exp_q.push_back(2'b01);
      while (exp_q.size() > 0) begin
         tick();
         exp = exp_q.pop_front();
         checks++;
         if ({g1, g2} !== exp) begin
            errors++;
            $display("FAIL regrant g1g2=%b required %b", {g1, g2}, exp);
         end
      end
      rst = 1'b1; r1 = 1'b1; r2 = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.push_back(2'b00); exp_q.push_back(2'b00); exp_q.push_back(2'b10);
      exp_q.push_back(2'b10);
      while (exp_q.size() > 0) begin
         tick();
         exp = exp_q.pop_front();
         checks++;
         if ({g1, g2} !== exp) begin
            errors++;
            $display("FAIL reset_tie g1g2=%b required %b", {g1, g2}, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp;
      r1 = 1'b0; r2 = 1'b0;
      repeat (5) tick();
      r1 = 1'b1;
      exp_q.push_back(2'b00); exp_q.push_back(2'b00); exp_q.push_back(2'b10);
      while (exp_q.size() > 0) begin
         tick();
         exp = exp_q.pop_front();
         checks++;
         if ({g1, g2} !== exp) begin
            errors++;
            $display("FAIL single_rise g1g2=%b required %b", {g1, g2}, exp);
         end
      end
      r1 = 1'b0;
      exp_q.push_back(2'b10); exp_q.push_back(2'b10); exp_q.push_back(2'b00);
      exp_q.push_back(2'b00);
      while (exp_q.size() > 0) begin
         tick();
         exp = exp_q.pop_front();
         checks++;
         if ({g1, g2} !== exp) begin
            errors++;
            $display("FAIL single_fall g1g2=%b required %b", {g1, g2}, exp);
         end
      end
      r2 = 1'b1;
      exp_q.push_back(2'b00); exp_q.push_back(2'b00); exp_q.push_back(2'b01);
      while (exp_q.size() > 0) begin
         tick();
         exp = exp_q.pop_front();
         checks++;
         if ({g1, g2} !== exp) begin
            errors++;
            $display("FAIL single_r2 g1g2=%b required %b", {g1, g2}, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_tie();
      test_drop_other();
      test_handover();
      test_alternate();
      test_reset_mid_grant();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
